// File: rtl/transmission8_rx_pkg.sv
// Shared types and defaults for the 8-channel TDM receive path.
// Frame geometry defaults and the receiver state encoding.
package transmission8_rx_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SEL_W_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/transmission8_rx_if.sv
// Link-side and frame-side signals of the TDM receiver.
// master drives the strobe/bit side; slave is the receiver.
interface transmission8_rx_if
  import transmission8_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
);

  logic             iSync;
  logic             iEn;
  logic             iBit;
  logic [SEL_W-1:0] oSel;
  logic [WIDTH-1:0] oData;
  logic             oValid;
  logic             oBusy;
  logic             oErr;

  modport master (
    output iSync, iEn, iBit,
    input  oSel, oData, oValid, oBusy, oErr
  );

  modport slave (
    input  iSync, iEn, iBit,
    output oSel, oData, oValid, oBusy, oErr
  );

endinterface

// File: rtl/transmission8_rx_chan_counter.sv
// Channel counter: load-to-1 on frame start, step, wrap to 0.
// Its value is the far-end select and the assembly write index.
module transmission8_rx_chan_counter
  import transmission8_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  output logic [SEL_W-1:0] cnt
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

  // load wins over step; last channel wraps back to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= SEL_W'(1);
    end else if (inc) begin
      cnt <= (cnt == LAST) ? '0 : cnt + SEL_W'(1);
    end
  end

endmodule

// File: rtl/transmission8_rx.sv
// Receive end of the 8-channel TDM link.
// Steps the far-end select and rebuilds each frame in parallel.
module transmission8_rx
  import transmission8_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic                iClk,
  input  logic                iRst_n,
  transmission8_rx_if.slave   bus
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

  state_t           state;
  state_t           stateNext;
  logic [SEL_W-1:0] cnt;
  logic [SEL_W-1:0] wrIdx;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shiftNext;
  logic             loadOne;
  logic             incCnt;
  logic             wrBit;
  logic             frameDone;
  logic             errNext;

  transmission8_rx_chan_counter #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) uCnt (
    .clk   (iClk),
    .rst_n (iRst_n),
    .load  (loadOne),
    .inc   (incCnt),
    .cnt   (cnt)
  );

  assign bus.oSel = cnt;

  // state register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // next state and per-strobe control
  always_comb begin
    stateNext = state;
    loadOne   = 1'b0;
    incCnt    = 1'b0;
    wrBit     = 1'b0;
    frameDone = 1'b0;
    errNext   = 1'b0;
    if (bus.iEn) begin
      unique case (state)
        IDLE: begin
          if (bus.iSync) begin
            loadOne   = 1'b1;
            wrBit     = 1'b1;
            stateNext = RECV;
          end
        end
        RECV: begin
          wrBit = 1'b1;
          unique case (1'b1)
            bus.iSync: begin
              errNext = 1'b1;
              loadOne = 1'b1;
            end
            (!bus.iSync && cnt == LAST): begin
              frameDone = 1'b1;
              incCnt    = 1'b1;
              stateNext = IDLE;
            end
            default: begin
              incCnt = 1'b1;
            end
          endcase
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // a restart always lands in channel 0
  assign wrIdx = loadOne ? '0 : cnt;

  // assembly word with this strobe's bit merged in
  always_comb begin
    shiftNext        = shift;
    shiftNext[wrIdx] = bus.iBit;
  end

  // assembly register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      shift <= '0;
    end else if (wrBit) begin
      shift <= shiftNext;
    end
  end

  // frame output and status pulses
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      bus.oData  <= '0;
      bus.oValid <= 1'b0;
      bus.oBusy  <= 1'b0;
      bus.oErr   <= 1'b0;
    end else begin
      if (frameDone) begin
        bus.oData <= shiftNext;
      end
      bus.oValid <= frameDone;
      bus.oErr   <= errNext;
      bus.oBusy  <= (stateNext == RECV);
    end
  end

endmodule

// File: tb/tb_transmission8_rx.sv
// Directed bench for transmission8_rx.
// Hand-computed frames, gaps, restarts and resets.
module tb_transmission8_rx;

  logic clk;
  logic rst_n;
  int   nChecks = 0;
  int   nFail   = 0;

  transmission8_rx_if #(.WIDTH(8), .SEL_W(3)) bus ();

  transmission8_rx #(.WIDTH(8), .SEL_W(3)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic e, input logic b);
    @(negedge clk);
    bus.iSync = s;
    bus.iEn   = e;
    bus.iBit  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] d, input int gapAfter,
                       input int gapLen);
    for (int k = 0; k < 8; k++) begin
      chk("selPre", bus.oSel, k);
      step(k == 0, 1'b1, d[k]);
      chk("errFrame", bus.oErr, 0);
      if (k < 7) begin
        chk("validMid", bus.oValid, 0);
        chk("busyMid", bus.oBusy, 1);
      end else begin
        chk("validEnd", bus.oValid, 1);
        chk("dataEnd", bus.oData, d);
        chk("busyEnd", bus.oBusy, 0);
      end
      if (k == gapAfter) begin
        for (int g = 0; g < gapLen; g++) begin
          step(1'b0, 1'b0, 1'b1);
          chk("selGap", bus.oSel, k + 1);
          chk("busyGap", bus.oBusy, 1);
          chk("validGap", bus.oValid, 0);
        end
      end
    end
  endtask

  task automatic idleChk(input string tag, input logic [7:0] d);
    chk({tag, "Sel"}, bus.oSel, 0);
    chk({tag, "Data"}, bus.oData, d);
    chk({tag, "Valid"}, bus.oValid, 0);
    chk({tag, "Busy"}, bus.oBusy, 0);
    chk({tag, "Err"}, bus.oErr, 0);
  endtask

  initial begin
    logic [7:0] v;
    rst_n     = 1'b0;
    bus.iSync = 1'b0;
    bus.iEn   = 1'b0;
    bus.iBit  = 1'b0;
    #3;
    idleChk("rst0", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    idleChk("postRst", 8'h00);

    // single frame
    frame(8'b1111_1110, -1, 0);
    step(1'b0, 1'b0, 1'b0);
    idleChk("single", 8'hFE);

    // gapped frame: 3 idle cycles after ch3
    frame(8'b1111_1110, 3, 3);
    step(1'b0, 1'b0, 1'b0);
    idleChk("gap", 8'hFE);

    // back-to-back frames
    frame(8'hA5, -1, 0);
    frame(8'h3C, -1, 0);
    step(1'b0, 1'b0, 1'b0);
    idleChk("b2b", 8'h3C);

    // mid-frame sync at cnt=5, then full 7F frame
    v = 8'h7F;
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 5; k++) step(1'b0, 1'b1, 1'b0);
    chk("selBeforeErr", bus.oSel, 5);
    step(1'b1, 1'b1, v[0]);
    chk("errPulse", bus.oErr, 1);
    chk("errNoValid", bus.oValid, 0);
    chk("errData", bus.oData, 8'h3C);
    chk("errSel", bus.oSel, 1);
    chk("errBusy", bus.oBusy, 1);
    for (int k = 1; k < 8; k++) begin
      step(1'b0, 1'b1, v[k]);
      chk("errClear", bus.oErr, 0);
      chk("restartValid", bus.oValid, (k == 7) ? 1 : 0);
    end
    chk("restartData", bus.oData, 8'h7F);

    // sync on last channel is a restart, not a completion
    v = 8'h81;
    step(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 7; k++) step(1'b0, 1'b1, 1'b1);
    chk("selLast", bus.oSel, 7);
    step(1'b1, 1'b1, v[0]);
    chk("lastErr", bus.oErr, 1);
    chk("lastNoValid", bus.oValid, 0);
    chk("lastData", bus.oData, 8'h7F);
    for (int k = 1; k < 8; k++) step(1'b0, 1'b1, v[k]);
    chk("lastValid", bus.oValid, 1);
    chk("lastErr2", bus.oErr, 0);
    chk("lastData2", bus.oData, 8'h81);

    // idle noise
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      idleChk("noise", 8'h81);
    end

    // async reset mid-frame
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("preRstSel", bus.oSel, 3);
    chk("preRstBusy", bus.oBusy, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    idleChk("asyncRst", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1);
    idleChk("afterRst", 8'h00);
    frame(8'h5A, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
